// File: rtl/collision_detector_pkg.sv
`default_nettype none
// ============================================================================
// Package     : collision_detector_pkg
// Description : Shared screen geometry, brick tiling and paddle segment bounds
//               for the per-pixel collision producer.
// Revision    : 1.0 - initial release
// ============================================================================
package collision_detector_pkg;

    localparam int c_screen_w        = 640;
    localparam int c_screen_h        = 480;
    localparam int c_border_width    = 8;
    localparam int c_paddle_y        = 456;
    localparam int c_paddle_h        = 4;

    // Bricks are 32x16 tiles, so the tile index is a plain bit slice.
    localparam int c_brick_col_shift = 5;
    localparam int c_brick_row_shift = 4;

    // First offset of paddle segments 1..5; segment 0 starts at offset 0.
    localparam int c_seg_b1 = 10;
    localparam int c_seg_b2 = 21;
    localparam int c_seg_b3 = 32;
    localparam int c_seg_b4 = 43;
    localparam int c_seg_b5 = 54;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_req  = 1'b1;

endpackage : collision_detector_pkg
`default_nettype wire

// File: rtl/collision_detector_paddle_segment_lut.sv
`default_nettype none
// ============================================================================
// Module      : collision_detector_paddle_segment_lut
// Description : Maps a 6-bit horizontal offset into the paddle onto one of
//               six bounce segments (0 = far left .. 5 = far right).
// Revision    : 1.0 - initial release
// ============================================================================
module collision_detector_paddle_segment_lut
    import collision_detector_pkg::*;
(
    input  logic [5:0] i_offset,
    output logic [2:0] o_segment
);

    always_comb begin
        o_segment = 3'd5;
        if (i_offset < 6'(c_seg_b1)) begin
            o_segment = 3'd0;
        end else if (i_offset < 6'(c_seg_b2)) begin
            o_segment = 3'd1;
        end else if (i_offset < 6'(c_seg_b3)) begin
            o_segment = 3'd2;
        end else if (i_offset < 6'(c_seg_b4)) begin
            o_segment = 3'd3;
        end else if (i_offset < 6'(c_seg_b5)) begin
            o_segment = 3'd4;
        end
    end

endmodule : collision_detector_paddle_segment_lut
`default_nettype wire

// File: rtl/collision_detector.sv
`default_nettype none
// ============================================================================
// Module      : collision_detector
// Description : Per-pixel ball-vs-solid overlap detection with registered
//               edge/source strobes and a first-brick-per-frame clear request.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_detector
    import collision_detector_pkg::*;
#(
    parameter int BALL_SIZE    = 4,
    parameter int PADDLE_WIDTH = 64,
    parameter int PADDLE_Y     = c_paddle_y,
    parameter int BORDER_WIDTH = c_border_width
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       frame_pulse,
    input  logic       display_on,
    input  logic [9:0] hpos,
    input  logic [8:0] vpos,
    input  logic [9:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic [9:0] paddle_x,
    input  logic       brick_pixel,
    output logic       collision,
    output logic       ball_top_col,
    output logic       ball_bottom_col,
    output logic       ball_left_col,
    output logic       ball_right_col,
    output logic       block_collision,
    output logic       paddle_collision,
    output logic [2:0] paddle_segment,
    output logic       clear_valid,
    output logic [4:0] clear_col,
    output logic [4:0] clear_row,
    input  logic       clear_ready
);

    logic [9:0]  r_sx;
    logic [8:0]  r_sy;
    logic [9:0]  r_px;
    logic [0:0]  r_state;
    logic        r_hit_taken;

    logic [10:0] w_h;
    logic [10:0] w_v;
    logic [10:0] w_sx;
    logic [10:0] w_sy;
    logic [10:0] w_px;
    logic        w_in_ball;
    logic        w_wall;
    logic        w_paddle;
    logic        w_hit;
    logic        w_top;
    logic        w_bottom;
    logic        w_left;
    logic        w_right;
    logic        w_capture;
    logic [5:0]  w_pad_off;
    logic [2:0]  w_seg;

    // Positions are frozen per frame so a moving ball never tears mid-scan.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_sx <= '0;
            r_sy <= '0;
            r_px <= '0;
        end else if (frame_pulse) begin
            r_sx <= ball_x;
            r_sy <= ball_y;
            r_px <= paddle_x;
        end
    end

    // Widened to 11 bits so sx+BALL_SIZE near the right edge cannot wrap.
    assign w_h  = {1'b0, hpos};
    assign w_v  = {2'b00, vpos};
    assign w_sx = {1'b0, r_sx};
    assign w_sy = {2'b00, r_sy};
    assign w_px = {1'b0, r_px};

    assign w_in_ball = (w_h >= w_sx) && (w_h < w_sx + 11'(BALL_SIZE)) &&
                       (w_v >= w_sy) && (w_v < w_sy + 11'(BALL_SIZE));

    assign w_wall = (w_h < 11'(BORDER_WIDTH)) ||
                    (w_h >= 11'(c_screen_w - BORDER_WIDTH)) ||
                    (w_v < 11'(BORDER_WIDTH));

    assign w_paddle = (w_h >= w_px) && (w_h < w_px + 11'(PADDLE_WIDTH)) &&
                      (w_v >= 11'(PADDLE_Y)) && (w_v < 11'(PADDLE_Y + c_paddle_h));

    assign w_hit    = display_on && w_in_ball && (w_wall || brick_pixel || w_paddle);

    assign w_top    = (w_v == w_sy);
    assign w_bottom = (w_v == w_sy + 11'(BALL_SIZE - 1));
    assign w_left   = (w_h == w_sx);
    assign w_right  = (w_h == w_sx + 11'(BALL_SIZE - 1));

    // Offset is only meaningful inside the paddle, where it fits in 6 bits.
    assign w_pad_off = hpos[5:0] - r_px[5:0];

    collision_detector_paddle_segment_lut u_seg_lut (
        .i_offset  (w_pad_off),
        .o_segment (w_seg)
    );

    always_ff @(posedge clk) begin
        if (!nRst) begin
            collision        <= 1'b0;
            ball_top_col     <= 1'b0;
            ball_bottom_col  <= 1'b0;
            ball_left_col    <= 1'b0;
            ball_right_col   <= 1'b0;
            block_collision  <= 1'b0;
            paddle_collision <= 1'b0;
            paddle_segment   <= 3'd0;
        end else begin
            collision        <= w_hit;
            ball_top_col     <= w_hit && w_top;
            ball_bottom_col  <= w_hit && w_bottom;
            ball_left_col    <= w_hit && w_left;
            ball_right_col   <= w_hit && w_right;
            block_collision  <= w_hit && brick_pixel;
            paddle_collision <= w_hit && w_paddle;
            paddle_segment   <= (w_hit && w_paddle) ? w_seg : 3'd0;
        end
    end

    assign w_capture = w_hit && brick_pixel && !r_hit_taken;

    // Only the first brick touched in a frame is removed.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state     <= c_st_idle;
            r_hit_taken <= 1'b0;
            clear_valid <= 1'b0;
            clear_col   <= 5'd0;
            clear_row   <= 5'd0;
        end else begin
            if (frame_pulse) begin
                r_hit_taken <= 1'b0;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_capture) begin
                        r_state     <= c_st_req;
                        r_hit_taken <= 1'b1;
                        clear_valid <= 1'b1;
                        clear_col   <= hpos[9:c_brick_col_shift];
                        clear_row   <= vpos[8:c_brick_row_shift];
                    end
                end
                c_st_req: begin
                    if (clear_ready) begin
                        r_state     <= c_st_idle;
                        clear_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule : collision_detector
`default_nettype wire

// File: tb/tb_collision_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_detector
// Description : Directed self-checking bench for collision_detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_detector;

    logic       clk = 1'b0;
    logic       nRst;
    logic       frame_pulse;
    logic       display_on;
    logic [9:0] hpos;
    logic [8:0] vpos;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [9:0] paddle_x;
    logic       brick_pixel;
    logic       collision;
    logic       ball_top_col;
    logic       ball_bottom_col;
    logic       ball_left_col;
    logic       ball_right_col;
    logic       block_collision;
    logic       paddle_collision;
    logic [2:0] paddle_segment;
    logic       clear_valid;
    logic [4:0] clear_col;
    logic [4:0] clear_row;
    logic       clear_ready;

    int total = 0;
    int bad   = 0;

    // {collision, top, bottom, left, right, block, paddle, segment[2:0]}
    logic [9:0]  w_out;
    logic [10:0] w_clr;
    assign w_out = {collision, ball_top_col, ball_bottom_col, ball_left_col, ball_right_col,
                    block_collision, paddle_collision, paddle_segment};
    assign w_clr = {clear_valid, clear_col, clear_row};

    always #5 clk = ~clk;

    collision_detector dut (
        .clk              (clk),
        .nRst             (nRst),
        .frame_pulse      (frame_pulse),
        .display_on       (display_on),
        .hpos             (hpos),
        .vpos             (vpos),
        .ball_x           (ball_x),
        .ball_y           (ball_y),
        .paddle_x         (paddle_x),
        .brick_pixel      (brick_pixel),
        .collision        (collision),
        .ball_top_col     (ball_top_col),
        .ball_bottom_col  (ball_bottom_col),
        .ball_left_col    (ball_left_col),
        .ball_right_col   (ball_right_col),
        .block_collision  (block_collision),
        .paddle_collision (paddle_collision),
        .paddle_segment   (paddle_segment),
        .clear_valid      (clear_valid),
        .clear_col        (clear_col),
        .clear_row        (clear_row),
        .clear_ready      (clear_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_frame(input logic [9:0] bx, input logic [8:0] by, input logic [9:0] px);
        ball_x      = bx;
        ball_y      = by;
        paddle_x    = px;
        display_on  = 1'b0;
        brick_pixel = 1'b0;
        frame_pulse = 1'b1;
        tick();
        frame_pulse = 1'b0;
    endtask

    // Presents one visible pixel; on return the outputs describe that pixel.
    task automatic pixel(input logic [9:0] h, input logic [8:0] v, input logic br);
        hpos        = h;
        vpos        = v;
        display_on  = 1'b1;
        brick_pixel = br;
        tick();
        display_on  = 1'b0;
        brick_pixel = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        nRst = 1'b0;
        tick();
        tick();
        exp = 10'd0;
        if (w_out !== exp) begin bad++; $display("FAIL reset_out: got %b want %b", w_out, exp); end
        total++;
        if (w_clr !== 11'd0) begin bad++; $display("FAIL reset_clear: got %h want 0", w_clr); end
        total++;
        nRst = 1'b1;
        // Shadows are 0 before the first frame: ball covers (0..3,0..3), all wall.
        pixel(10'd1, 9'd1, 1'b0);
        exp = {1'b1, 4'b0000, 2'b00, 3'd0};
        if (w_out !== exp) begin bad++; $display("FAIL reset_shadow_interior: got %b want %b", w_out, exp); end
        total++;
        tick();
        if (w_out !== 10'd0) begin bad++; $display("FAIL one_cycle_strobe: got %b want 0", w_out); end
        total++;
    endtask

    task automatic test_wall();
        logic [9:0] exp;
        new_frame(10'd6, 9'd100, 10'd290);
        pixel(10'd6, 9'd101, 1'b0);
        exp = {1'b1, 4'b0010, 2'b00, 3'd0};
        if (w_out !== exp) begin bad++; $display("FAIL wall_left: got %b want %b", w_out, exp); end
        total++;
        pixel(10'd6, 9'd100, 1'b0);
        exp = {1'b1, 4'b1010, 2'b00, 3'd0};
        if (w_out !== exp) begin bad++; $display("FAIL wall_corner: got %b want %b", w_out, exp); end
        total++;
        pixel(10'd8, 9'd101, 1'b0);
        if (w_out !== 10'd0) begin bad++; $display("FAIL wall_edge_x8: got %b want 0", w_out); end
        total++;
    endtask

    task automatic test_paddle();
        logic [9:0] exp;
        new_frame(10'd300, 9'd453, 10'd290);
        pixel(10'd300, 9'd456, 1'b0);
        exp = {1'b1, 4'b0110, 2'b01, 3'd1};
        if (w_out !== exp) begin bad++; $display("FAIL paddle_bl: got %b want %b", w_out, exp); end
        total++;
        pixel(10'd303, 9'd456, 1'b0);
        exp = {1'b1, 4'b0101, 2'b01, 3'd1};
        if (w_out !== exp) begin bad++; $display("FAIL paddle_br: got %b want %b", w_out, exp); end
        total++;
        pixel(10'd301, 9'd455, 1'b0);
        if (w_out !== 10'd0) begin bad++; $display("FAIL paddle_above: got %b want 0", w_out); end
        total++;
        new_frame(10'd342, 9'd456, 10'd290);
        pixel(10'd343, 9'd456, 1'b0);
        exp = {1'b1, 4'b1000, 2'b01, 3'd4};
        if (w_out !== exp) begin bad++; $display("FAIL seg_o53: got %b want %b", w_out, exp); end
        total++;
        pixel(10'd344, 9'd456, 1'b0);
        exp = {1'b1, 4'b1000, 2'b01, 3'd5};
        if (w_out !== exp) begin bad++; $display("FAIL seg_o54: got %b want %b", w_out, exp); end
        total++;
        new_frame(10'd351, 9'd456, 10'd290);
        pixel(10'd353, 9'd456, 1'b0);
        exp = {1'b1, 4'b1000, 2'b01, 3'd5};
        if (w_out !== exp) begin bad++; $display("FAIL seg_o63: got %b want %b", w_out, exp); end
        total++;
        pixel(10'd354, 9'd456, 1'b0);
        if (w_out !== 10'd0) begin bad++; $display("FAIL paddle_past_right: got %b want 0", w_out); end
        total++;
        new_frame(10'd288, 9'd456, 10'd290);
        pixel(10'd290, 9'd456, 1'b0);
        exp = {1'b1, 4'b1000, 2'b01, 3'd0};
        if (w_out !== exp) begin bad++; $display("FAIL seg_o0: got %b want %b", w_out, exp); end
        total++;
        pixel(10'd289, 9'd456, 1'b0);
        if (w_out !== 10'd0) begin bad++; $display("FAIL paddle_before_left: got %b want 0", w_out); end
        total++;
    endtask

    task automatic test_brick();
        logic [9:0] exp;
        clear_ready = 1'b0;
        new_frame(10'd200, 9'd64, 10'd290);
        pixel(10'd200, 9'd64, 1'b1);
        exp = {1'b1, 4'b1010, 2'b10, 3'd0};
        if (w_out !== exp) begin bad++; $display("FAIL brick_hit: got %b want %b", w_out, exp); end
        total++;
        if (w_clr !== {1'b1, 5'd6, 5'd4}) begin bad++; $display("FAIL brick_req: got %h want %h", w_clr, {1'b1, 5'd6, 5'd4}); end
        total++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (w_clr !== {1'b1, 5'd6, 5'd4}) begin bad++; $display("FAIL brick_hold%0d: got %h want %h", i, w_clr, {1'b1, 5'd6, 5'd4}); end
            total++;
        end
        clear_ready = 1'b1;
        tick();
        clear_ready = 1'b0;
        if (clear_valid !== 1'b0) begin bad++; $display("FAIL brick_accept: got %b want 0", clear_valid); end
        total++;
        pixel(10'd201, 9'd65, 1'b1);
        exp = {1'b1, 4'b0000, 2'b10, 3'd0};
        if (w_out !== exp) begin bad++; $display("FAIL brick_second_hit: got %b want %b", w_out, exp); end
        total++;
        if (clear_valid !== 1'b0) begin bad++; $display("FAIL brick_second_ignored: got %b want 0", clear_valid); end
        total++;
        new_frame(10'd200, 9'd64, 10'd290);
        pixel(10'd203, 9'd67, 1'b1);
        exp = {1'b1, 4'b0101, 2'b10, 3'd0};
        if (w_out !== exp) begin bad++; $display("FAIL brick_next_frame_hit: got %b want %b", w_out, exp); end
        total++;
        if (w_clr !== {1'b1, 5'd6, 5'd4}) begin bad++; $display("FAIL brick_next_frame_req: got %h want %h", w_clr, {1'b1, 5'd6, 5'd4}); end
        total++;
        clear_ready = 1'b1;
        tick();
        clear_ready = 1'b0;
    endtask

    task automatic test_freeze();
        logic [9:0] exp;
        new_frame(10'd6, 9'd100, 10'd290);
        ball_x = 10'd300;
        pixel(10'd6, 9'd101, 1'b0);
        exp = {1'b1, 4'b0010, 2'b00, 3'd0};
        if (w_out !== exp) begin bad++; $display("FAIL freeze_old_pos: got %b want %b", w_out, exp); end
        total++;
        new_frame(10'd300, 9'd100, 10'd290);
        pixel(10'd6, 9'd101, 1'b0);
        if (w_out !== 10'd0) begin bad++; $display("FAIL freeze_new_pos: got %b want 0", w_out); end
        total++;
    endtask

    task automatic test_display_off();
        new_frame(10'd6, 9'd100, 10'd290);
        hpos       = 10'd6;
        vpos       = 9'd101;
        display_on = 1'b0;
        tick();
        if (w_out !== 10'd0) begin bad++; $display("FAIL display_off: got %b want 0", w_out); end
        total++;
    endtask

    task automatic test_frame_coincident();
        logic [9:0] exp;
        new_frame(10'd6, 9'd100, 10'd290);
        ball_x      = 10'd300;
        hpos        = 10'd6;
        vpos        = 9'd101;
        display_on  = 1'b1;
        frame_pulse = 1'b1;
        tick();
        display_on  = 1'b0;
        frame_pulse = 1'b0;
        exp = {1'b1, 4'b0010, 2'b00, 3'd0};
        if (w_out !== exp) begin bad++; $display("FAIL coincident_hit: got %b want %b", w_out, exp); end
        total++;
        pixel(10'd6, 9'd101, 1'b0);
        if (w_out !== 10'd0) begin bad++; $display("FAIL coincident_shadow: got %b want 0", w_out); end
        total++;
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp;
        clear_ready = 1'b0;
        new_frame(10'd200, 9'd64, 10'd290);
        pixel(10'd200, 9'd64, 1'b1);
        if (clear_valid !== 1'b1) begin bad++; $display("FAIL rmid_req: got %b want 1", clear_valid); end
        total++;
        hpos        = 10'd200;
        vpos        = 9'd64;
        display_on  = 1'b1;
        brick_pixel = 1'b1;
        nRst        = 1'b0;
        tick();
        tick();
        if (w_out !== 10'd0) begin bad++; $display("FAIL rmid_out: got %b want 0", w_out); end
        total++;
        if (w_clr !== 11'd0) begin bad++; $display("FAIL rmid_clear: got %h want 0", w_clr); end
        total++;
        nRst        = 1'b1;
        display_on  = 1'b0;
        brick_pixel = 1'b0;
        pixel(10'd1, 9'd1, 1'b1);
        exp = {1'b1, 4'b0000, 2'b10, 3'd0};
        if (w_out !== exp) begin bad++; $display("FAIL rmid_after_hit: got %b want %b", w_out, exp); end
        total++;
        if (w_clr !== {1'b1, 5'd0, 5'd0}) begin bad++; $display("FAIL rmid_after_req: got %h want %h", w_clr, {1'b1, 5'd0, 5'd0}); end
        total++;
        clear_ready = 1'b1;
        tick();
        clear_ready = 1'b0;
    endtask

    initial begin
        nRst        = 1'b0;
        frame_pulse = 1'b0;
        display_on  = 1'b0;
        hpos        = 10'd0;
        vpos        = 9'd0;
        ball_x      = 10'd0;
        ball_y      = 9'd0;
        paddle_x    = 10'd0;
        brick_pixel = 1'b0;
        clear_ready = 1'b0;
        test_reset();
        test_wall();
        test_paddle();
        test_brick();
        test_freeze();
        test_display_off();
        test_frame_coincident();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_collision_detector
`default_nettype wire
